// File: rtl/mux2x1_pkg.sv
// Shared constants for the registered 2:1 selector and its skid buffer.
// The occupancy enum doubles as the skid buffer's state encoding.
package mux2x1_pkg;

    localparam int MUX2X1_WIDTH_DEFAULT = 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/mux2x1_skid.sv
// Generic 2-entry skid buffer with valid/ready on both sides.
// The head register drives the output; the spare register fills only while the head is stalled.
module mux2x1_skid
    import mux2x1_pkg::*;
#(
    parameter int WIDTH = MUX2X1_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    occ_e             occ, occ_nxt;
    logic [WIDTH-1:0] head, head_nxt;
    logic [WIDTH-1:0] spare, spare_nxt;
    logic             push, pop;

    // Ready comes only from registered occupancy and reset, never from out_ready.
    assign in_ready  = rst_n && (occ != FULL);
    assign out_valid = (occ != EMPTY);
    assign out_data  = head;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        occ_nxt   = occ;
        head_nxt  = head;
        spare_nxt = spare;
        case (occ)
            EMPTY: begin
                if (push) begin
                    head_nxt = in_data;
                    occ_nxt  = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = in_data;
                end else if (push) begin
                    spare_nxt = in_data;
                    occ_nxt   = FULL;
                end else if (pop) begin
                    // Head keeps its value so the output holds the last result.
                    occ_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_nxt = spare;
                    occ_nxt  = ONE;
                end
            end
            default: begin
                occ_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ   <= EMPTY;
            head  <= '0;
            spare <= '0;
        end else begin
            occ   <= occ_nxt;
            head  <= head_nxt;
            spare <= spare_nxt;
        end
    end

endmodule

// File: rtl/mux2x1.sv
// Registered 2:1 selector: picks A (S=1) or B, then queues the result in a skid buffer.
module mux2x1
    import mux2x1_pkg::*;
#(
    parameter int WIDTH = MUX2X1_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] sel;

    // An if/else makes an unknown select fall through to B.
    always_comb begin
        if (S) sel = A;
        else   sel = B;
    end

    mux2x1_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (Y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_mux2x1.sv
// Self-checking bench for mux2x1: directed test-plan steps then random traffic,
// checked against a queue model of a 2-deep FIFO.
module tb_mux2x1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B, Y;
    logic         S, in_valid, in_ready, out_valid, out_ready;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] last_y;

    always #5 clk = ~clk;

    mux2x1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .S         (S),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance one clock and update the model.
    task automatic cycle(input string tag);
        bit           push, pop;
        logic [W-1:0] r;
        #1;
        chk({tag, ".in_ready"},  W'(rst_n === 1'b1 && q.size() < 2), W'(in_ready));
        chk({tag, ".out_valid"}, W'(out_valid), W'(q.size() > 0));
        chk({tag, ".y"},         Y, last_y);
        push = (in_valid === 1'b1) && (rst_n === 1'b1) && (q.size() < 2);
        pop  = (q.size() > 0) && (out_ready === 1'b1);
        r    = (S === 1'b1) ? A : B;
        @(posedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            q.delete();
            last_y = '0;
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(r);
            if (q.size() > 0) last_y = q[0];
        end
    endtask

    initial begin
        rst_n = 1'b0; A = '0; B = '0; S = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        last_y = '0;
        @(posedge clk);
        #1;
        cycle("reset");
        cycle("reset");

        // Release: in_ready must be 1 in the first cycle out of reset.
        rst_n = 1'b1;
        cycle("release");

        // Select sweep at full throughput.
        out_ready = 1'b1; in_valid = 1'b1;
        S = 1'b1; A = 8'd0; B = 8'd1; cycle("sweep0");
        A = 8'd1; B = 8'd0;           cycle("sweep1");
        S = 1'b0;                     cycle("sweep2");
        A = 8'd0; B = 8'd1;           cycle("sweep3");
        in_valid = 1'b0;              cycle("sweep4");
        chk("sweep_last_y", Y, 8'd1);
        cycle("sweep5");

        // Back-pressure: two accepted, third waits for in_ready.
        out_ready = 1'b0; in_valid = 1'b1; S = 1'b1; B = 8'd0;
        A = 8'd1; cycle("bp0");
        A = 8'd0; cycle("bp1");
        A = 8'd1; cycle("bp2");
        chk("bp_full_ready", W'(in_ready), W'(0));
        chk("bp_hold_y", Y, 8'd1);
        cycle("bp3");
        out_ready = 1'b1;
        cycle("bp4");
        cycle("bp5");
        in_valid = 1'b0;
        cycle("bp6");
        cycle("bp7");

        // Simultaneous push/pop with one entry held.
        out_ready = 1'b1; in_valid = 1'b1; S = 1'b0; A = 8'h00;
        B = 8'h5A; cycle("pp0");
        B = 8'hA5; cycle("pp1");
        chk("pp_y", Y, 8'hA5);
        chk("pp_ready", W'(in_ready), W'(1));
        in_valid = 1'b0; cycle("pp2");
        cycle("pp3");

        // Reset with the buffer full.
        out_ready = 1'b0; in_valid = 1'b1; S = 1'b1; A = 8'h11; cycle("rm0");
        A = 8'h22; cycle("rm1");
        cycle("rm2");
        rst_n = 1'b0; out_ready = 1'b1; cycle("rm_rst");
        rst_n = 1'b1; in_valid = 1'b0; cycle("rm_rel");
        chk("rm_y", Y, 8'h00);
        in_valid = 1'b1; S = 1'b1; A = 8'h77; cycle("rm_push");
        in_valid = 1'b0; cycle("rm_out");
        cycle("rm_drain");

        // Unknown select resolves to B.
        in_valid = 1'b1; S = 1'bx; A = 8'd1; B = 8'd0; cycle("xsel");
        in_valid = 1'b0; S = 1'b0; cycle("xsel_out");
        chk("xsel_y", Y, 8'd0);

        // Idle: output holds its last value.
        in_valid = 1'b1; S = 1'b1; A = 8'hC3; cycle("idle_load");
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = W'($urandom); B = W'($urandom); S = 1'($urandom);
            cycle("idle");
        end
        chk("idle_y", Y, 8'hC3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            A         = W'($urandom);
            B         = W'($urandom);
            S         = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            cycle("rand");
        end
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cycle("final0");
        cycle("final1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
